mul2add: RTL and testbench
==========================

# mul2add

Serial value rebuilder: the inverse of the divmod2 chain. It consumes the stream of remainder bits that repeated divide-by-2 steps produce, least significant bit first. It rebuilds the original binary value as q*2+r steps, one bit per accepted strobe. It sits in the ALU beside divmod2 and uses the same activate/endop handshake. Its output is the check value in divmod round-trip benches.

## Interface
Parameters:
- WIDTH, 8, width of the rebuilt value
- CW, $clog2(WIDTH+1), width of the bit counter

Ports:
- clk  in  1  single clock, all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- activate  in  1  operation request; must stay high for the whole operation
- bit_valid  in  1  strobe: mod2 carries a bit this cycle
- mod2  in  1  remainder bit, LSB first
- last  in  1  qualifies bit_valid: this bit is the final one
- a  out  WIDTH  rebuilt value
- nbits  out  CW  number of bits stored in a (saturates at WIDTH)
- busy  out  1  high in ACCUM
- endop  out  1  one-cycle completion pulse
- overflow  out  1  a bit of 1 arrived beyond position WIDTH-1

## Operation
- States: IDLE, ACCUM, DONE, HOLD. All outputs are registered or decoded from state.
- Reset values: state=IDLE, a=0, nbits=0, busy=0, endop=0, overflow=0.
- IDLE, activate=1: clear a, nbits and overflow, then go to ACCUM. bit_valid is ignored in IDLE.
- ACCUM with activate=0: abort. Go to IDLE, clear a, nbits and overflow, and do not pulse endop. Abort has priority over a simultaneous bit_valid or last.
- ACCUM, bit_valid=1, nbits<WIDTH: a[nbits] <= mod2 and nbits <= nbits+1.
- ACCUM, bit_valid=1, nbits==WIDTH: a and nbits are unchanged. If mod2=1, overflow <= 1 (sticky until the next start). If mod2=0, the bit is ignored.
- ACCUM, bit_valid=1, last=1: store the bit per the rules above, then go to DONE.
- ACCUM, bit_valid=0: hold state. Gaps between bits have unlimited length.
- last without bit_valid has no effect.
- DONE: endop=1 for exactly this one cycle. Next state is HOLD if activate=1, else IDLE.
- HOLD: wait until activate=0, then go to IDLE. A held activate never restarts the block.
- a, nbits and overflow keep their values after DONE until the next start or reset.
- Value rule: a = sum of mod2_i * 2^i for i < nbits. Bits not written are 0.

## Timing
- Edge E0 samples activate=1 in IDLE. busy=1 from E0 onward.
- The first bit can be sampled at edge E1.
- The edge that samples the last bit also updates a and nbits. endop is high in the cycle right after that edge.
- Minimum operation with k bits back-to-back: endop is high during the cycle after edge E(k).
- reset is asynchronous. Asserting it in any state forces all outputs to their reset values at once. The first start after release needs activate sampled high in IDLE.

## Structure
- Shared ALU package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2, ST_HOLD=2'd3;
  - the default WIDTH=8, shared with divmod2.
- One sub-module, count_sat: a CW-bit counter with clear, increment enable, and a saturate-at-WIDTH output flag. It drives nbits and the bit index into a.
- The top level holds the FSM, the value register and the overflow flag.

## Test plan
- Round trip 13: reset, then activate; bits 1,0,1,1 with last on the 4th -> a=13, nbits=4, endop high one cycle, overflow=0.
- Full width 0xA5: 8 bits 1,0,1,0,0,1,0,1 with 2-cycle gaps and last on the 8th -> a=165, nbits=8, busy low after DONE.
- Overflow: 9 bits, with the first 8 encoding 0x0F and the 9th =1 with last -> a=15, nbits=8, overflow=1. Repeat with 9th =0 -> overflow=0.
- Abort: 2 bits (1,1), then activate=0 in the same cycle as bit_valid&last -> no endop, a=0, nbits=0, IDLE.
- Held activate: after endop, keep activate=1 for 5 cycles -> state HOLD, no restart, a stays valid. Drop activate, then raise it -> a clears, new op accepted.
- Reset mid-op: assert reset between clock edges after 3 bits -> all outputs 0 immediately, with no endop.

Source files
------------

// File: rtl/mul2add_pkg.sv
// Shared ALU definitions: default operand width and the activate/endop FSM encoding
// used by the divmod2 / mul2add pair.
package mul2add_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE,
    S_HOLD  = ST_HOLD
  } alu_state_t;

endpackage

// File: rtl/count_sat.sv
// Bit counter with clear and increment enable; stops at WIDTH and flags saturation.
// Clear wins over increment; increments while saturated are dropped.
module count_sat
  import mul2add_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CW'(WIDTH));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul2add.sv
// Serial value rebuilder: shifts LSB-first remainder bits into a, one per bit_valid strobe.
// Bits past WIDTH are dropped; a dropped 1 sets the sticky overflow flag.
module mul2add
  import mul2add_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             bit_valid,
  input  logic             mod2,
  input  logic             last,
  output logic [WIDTH-1:0] a,
  output logic [CW-1:0]    nbits,
  output logic             busy,
  output logic             endop,
  output logic             overflow
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             ovf_q, ovf_d;
  logic             cnt_clr, cnt_inc, cnt_sat;
  logic [CW-1:0]    cnt;

  count_sat #(.WIDTH(WIDTH), .CW(CW)) u_count_sat (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .sat_o (cnt_sat)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (activate) begin
          a_d     = '0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Abort outranks any bit or last arriving on the same edge.
        if (!activate) begin
          a_d     = '0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end else if (bit_valid) begin
          if (!cnt_sat) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt == CW'(i)) a_d[i] = mod2;
            end
            cnt_inc = 1'b1;
          end else if (mod2) begin
            ovf_d = 1'b1;
          end
          if (last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = activate ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!activate) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
    end
  end

  assign a        = a_q;
  assign nbits    = cnt;
  assign overflow = ovf_q;
  assign busy     = (state_q == S_ACCUM);
  assign endop    = (state_q == S_DONE);

endmodule

// File: tb/tb_mul2add.sv
// Directed-vector bench for mul2add: round trips, full width, overflow, abort, held activate, async reset.
module tb_mul2add;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             activate;
  logic             bit_valid;
  logic             mod2;
  logic             last;
  logic [WIDTH-1:0] a;
  logic [CW-1:0]    nbits;
  logic             busy;
  logic             endop;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul2add #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .bit_valid (bit_valid),
    .mod2      (mod2),
    .last      (last),
    .a         (a),
    .nbits     (nbits),
    .busy      (busy),
    .endop     (endop),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic l);
    bit_valid = 1'b1;
    mod2      = b;
    last      = l;
    tick();
    bit_valid = 1'b0;
    mod2      = 1'b0;
    last      = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ea, input logic [31:0] en,
                            input logic eb, input logic ee, input logic eo);
    chk({tag, ".a"},        32'(a),        ea);
    chk({tag, ".nbits"},    32'(nbits),    en);
    chk({tag, ".busy"},     32'(busy),     32'(eb));
    chk({tag, ".endop"},    32'(endop),    32'(ee));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
  endtask

  logic [7:0] vec_a5 = 8'hA5;

  initial begin
    reset = 1'b1; activate = 1'b0; bit_valid = 1'b0; mod2 = 1'b0; last = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Round trip 13: bits 1,0,1,1 back-to-back
    activate = 1'b1;
    tick();
    check_outs("rt13_start", 0, 0, 1, 0, 0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check_outs("rt13_mid", 5, 3, 1, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("rt13_done", 13, 4, 0, 1, 0);
    activate = 1'b0;
    tick();
    check_outs("rt13_after", 13, 4, 0, 0, 0);

    // Full width 0xA5 with 2-cycle gaps
    activate = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      send_bit(vec_a5[i], (i == 7) ? 1'b1 : 1'b0);
      if (i != 7) begin
        tick(); tick();
      end
    end
    check_outs("a5_done", 165, 8, 0, 1, 0);
    activate = 1'b0;
    tick();
    check_outs("a5_after", 165, 8, 0, 0, 0);

    // Overflow: 0x0F then a 9th bit of 1
    activate = 1'b1;
    tick();
    check_outs("ovf1_start", 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) send_bit((i < 4) ? 1'b1 : 1'b0, 1'b0);
    check_outs("ovf1_full", 15, 8, 1, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("ovf1_done", 15, 8, 0, 1, 1);
    activate = 1'b0;
    tick();
    chk("ovf1_sticky", 32'(overflow), 1);

    // Same, 9th bit 0: start clears the sticky flag and no overflow follows
    activate = 1'b1;
    tick();
    check_outs("ovf0_start", 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) send_bit((i < 4) ? 1'b1 : 1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    check_outs("ovf0_done", 15, 8, 0, 1, 0);
    activate = 1'b0;
    tick();

    // Abort coinciding with bit_valid & last
    activate = 1'b1;
    tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_outs("abort_mid", 3, 2, 1, 0, 0);
    activate = 1'b0;
    send_bit(1'b1, 1'b1);
    check_outs("abort", 0, 0, 0, 0, 0);
    tick();
    check_outs("abort_after", 0, 0, 0, 0, 0);

    // Held activate: no restart, value stays
    activate = 1'b1;
    tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_outs("hold_done", 1, 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; mod2 = 1'b1;
      tick();
      check_outs($sformatf("hold%0d", i), 1, 2, 0, 0, 0);
    end
    bit_valid = 1'b0; mod2 = 1'b0;
    activate = 1'b0;
    tick();
    check_outs("hold_drop", 1, 2, 0, 0, 0);
    activate = 1'b1;
    tick();
    check_outs("hold_restart", 0, 0, 1, 0, 0);
    send_bit(1'b1, 1'b1);
    check_outs("hold_newop", 1, 1, 0, 1, 0);
    activate = 1'b0;
    tick();

    // Async reset mid-op after 3 bits
    activate = 1'b1;
    tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_outs("rst_pre", 7, 3, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0, 0);
    tick();
    check_outs("rst_held", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_outs("rst_restart", 0, 0, 1, 0, 0);
    activate = 1'b0;
    tick();
    check_outs("rst_final", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
